// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } hazard_state_e;

  localparam int CNT_W    = 4;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with enable, used for optional hazard statistics.
module hazard_perf_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Holds at all ones once reached so long runs never wrap back to small values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, multi-cycle op stalls, branch flush, load-use stall.
// Optional statistics outputs are built when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_BITS = 5,
  parameter int MUL_LAT  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] D_rs1,
  input  logic [REG_BITS-1:0] D_rs2,
  input  logic                D_uses_rs1,
  input  logic                D_uses_rs2,
  input  logic [REG_BITS-1:0] E_rd,
  input  logic                E_reg_write,
  input  logic                E_is_load,
  input  logic                E_mc_start,
  input  logic                E_branch_taken,
  input  logic                M_mem_req,
  input  logic                M_mem_ready,
  output logic                stall_F,
  output logic                stall_D,
  output logic                stall_E,
  output logic                stall_M,
  output logic                flush_D,
  output logic                flush_E,
  output logic                mc_busy
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]         perf_stall_cycles,
  output logic [31:0]         perf_flushes
`endif
);

  hazard_state_e    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             mem_freeze;
  logic             load_use;

  assign mem_freeze = M_mem_req && !M_mem_ready;

  assign load_use = E_is_load && E_reg_write && (E_rd != REG_BITS'(REG_ZERO)) &&
                    ((D_uses_rs1 && (D_rs1 == E_rd)) || (D_uses_rs2 && (D_rs2 == E_rd)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are gated by reset so an op in flight drops its stalls without waiting for a clock.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_F   = 1'b0;
    stall_D   = 1'b0;
    stall_E   = 1'b0;
    stall_M   = 1'b0;
    flush_D   = 1'b0;
    flush_E   = 1'b0;
    if (rst) begin
      if (mem_freeze) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
      end else if (state == MC_BUSY) begin
        if (cnt > CNT_W'(1)) begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          stall_E = 1'b1;
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end else if (E_branch_taken) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (E_mc_start) begin
        stall_F   = 1'b1;
        stall_D   = 1'b1;
        stall_E   = 1'b1;
        cnt_nxt   = CNT_W'(MUL_LAT - 1);
        state_nxt = MC_BUSY;
      end else if (load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  assign mc_busy = rst && (state == MC_BUSY);

`ifdef HAZARD_CTRL_PERF_EN
  hazard_perf_cnt #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_D),
    .count (perf_stall_cycles)
  );

  hazard_perf_cnt #(.WIDTH(32)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (flush_D),
    .count (perf_flushes)
  );
`else
  // Statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; output vector order is
// {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mc_busy}.
module tb_hazard_ctrl;

  localparam int REG_BITS = 5;
  localparam int MUL_LAT  = 3;

  logic                clk;
  logic                rst;
  logic [REG_BITS-1:0] D_rs1, D_rs2, E_rd;
  logic                D_uses_rs1, D_uses_rs2;
  logic                E_reg_write, E_is_load, E_mc_start, E_branch_taken;
  logic                M_mem_req, M_mem_ready;
  logic                stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mc_busy;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0]         perf_stall_cycles, perf_flushes;
`endif
  logic [6:0]          outs;

  int vecCount  = 0;
  int missCount = 0;
  int expStall  = 0;
  int expFlush  = 0;

  hazard_ctrl #(.REG_BITS(REG_BITS), .MUL_LAT(MUL_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .D_rs1          (D_rs1),
    .D_rs2          (D_rs2),
    .D_uses_rs1     (D_uses_rs1),
    .D_uses_rs2     (D_uses_rs2),
    .E_rd           (E_rd),
    .E_reg_write    (E_reg_write),
    .E_is_load      (E_is_load),
    .E_mc_start     (E_mc_start),
    .E_branch_taken (E_branch_taken),
    .M_mem_req      (M_mem_req),
    .M_mem_ready    (M_mem_ready),
    .stall_F        (stall_F),
    .stall_D        (stall_D),
    .stall_E        (stall_E),
    .stall_M        (stall_M),
    .flush_D        (flush_D),
    .flush_E        (flush_E),
    .mc_busy        (mc_busy)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
`endif
  );

  assign outs = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mc_busy};

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [REG_BITS-1:0] rs1, input logic u1,
                               input logic [REG_BITS-1:0] rs2, input logic u2,
                               input logic [REG_BITS-1:0] rd, input logic rw, input logic ld,
                               input logic mc, input logic br, input logic req, input logic rdy);
    D_rs1 = rs1; D_uses_rs1 = u1;
    D_rs2 = rs2; D_uses_rs2 = u2;
    E_rd = rd; E_reg_write = rw; E_is_load = ld;
    E_mc_start = mc; E_branch_taken = br;
    M_mem_req = req; M_mem_ready = rdy;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Check mid-cycle, then let the edge commit and track the expected statistics.
  task automatic runVector(input string tag, input logic [6:0] exp);
    @(negedge clk);
    checkOutput(tag, {25'd0, outs}, {25'd0, exp});
    @(posedge clk);
    if (exp[5]) expStall++;
    if (exp[2]) expFlush++;
    #1;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    idle();
    M_mem_req = 1'b1;
    #2;
    checkOutput("reset_freeze", {25'd0, outs}, 32'd0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    idle();                                                                                 runVector("idle",        7'b0000000);
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);       runVector("loaduse",     7'b1100010);
    idle();                                                                                 runVector("loaduse_end", 7'b0000000);
    applyStimulus(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);       runVector("x0",          7'b0000000);
    applyStimulus(5'd3, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);       runVector("loaduse_rs2", 7'b1100010);
    applyStimulus(5'd5, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);       runVector("no_use",      7'b0000000);
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);       runVector("not_load",    7'b0000000);
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);       runVector("branch_lu",   7'b0000110);

    // Multi-cycle op: two stall cycles, busy ignores branch and load-use.
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);       runVector("mc_start",    7'b1110000);
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);       runVector("mc_busy1",    7'b1110001);
    idle();                                                                                 runVector("mc_busy2",    7'b0000001);
    idle();                                                                                 runVector("mc_done",     7'b0000000);

    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);       runVector("mc_br",       7'b0000110);
    idle();                                                                                 runVector("mc_br_after", 7'b0000000);
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);       runVector("freeze_run",  7'b1111000);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);       runVector("req_ready",   7'b0000000);

    // Freeze for four cycles while busy; the op resumes where it stopped.
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);       runVector("mc2_start",   7'b1110000);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);     runVector("mc_freeze",   7'b1111001);
    end
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);       runVector("mc_resume",   7'b1110001);
    idle();                                                                                 runVector("mc_last",     7'b0000001);
    idle();                                                                                 runVector("mc_run",      7'b0000000);

`ifdef HAZARD_CTRL_PERF_EN
    checkOutput("perf_stall", perf_stall_cycles, expStall);
    checkOutput("perf_flush", perf_flushes, expFlush);
`endif

    // Reset between edges while busy.
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);       runVector("mc3_start",   7'b1110000);
    idle();
    #2;
    checkOutput("pre_reset", {25'd0, outs}, {25'd0, 7'b1110001});
    rst = 1'b0;
    #1;
    checkOutput("reset_mid", {25'd0, outs}, 32'd0);
`ifdef HAZARD_CTRL_PERF_EN
    checkOutput("perf_stall_rst", perf_stall_cycles, 32'd0);
    checkOutput("perf_flush_rst", perf_flushes, 32'd0);
`endif
    expStall = 0;
    expFlush = 0;
    rst = 1'b1;
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);       runVector("post_reset",  7'b1100010);
    idle();                                                                                 runVector("post_idle",   7'b0000000);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_BITS, default 5, meaning register-index width.
REQ-002 The block SHALL have parameter MUL_LAT, default 3, meaning total E-stage cycles of a multi-cycle op; legal values are 2..15.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have these inputs: D_rs1 and D_rs2 (REG_BITS each, D-stage source indices); D_uses_rs1 and D_uses_rs2 (1 each, source valid).
REQ-005 The block SHALL have these inputs: E_rd (REG_BITS, E-stage destination); E_reg_write, E_is_load, E_mc_start, E_branch_taken (1 each).
REQ-006 The block SHALL have these inputs: M_mem_req and M_mem_ready (1 each, M-stage memory handshake).
REQ-007 The block SHALL have these outputs: stall_F, stall_D, stall_E, stall_M, flush_D, flush_E (1 each); mc_busy (1, FSM in MC_BUSY).

Function
REQ-008 mem_freeze SHALL equal M_mem_req AND NOT M_mem_ready, combinationally.
REQ-009 While mem_freeze is high, stall_F, stall_D, stall_E and stall_M SHALL be 1, flush_D and flush_E SHALL be 0, and the FSM state, counter and all other inputs SHALL be ignored or frozen.
REQ-010 The FSM SHALL have two states, RUN and MC_BUSY, plus a counter cnt of 4 bits.
REQ-011 In RUN with no freeze, E_mc_start=1 SHALL assert stall_F, stall_D and stall_E in the same cycle, load cnt with MUL_LAT-1, and move the FSM to MC_BUSY.
REQ-012 In MC_BUSY with no freeze, stall_F, stall_D and stall_E SHALL be 1 while cnt>1, and cnt SHALL decrement each cycle.
REQ-013 In MC_BUSY with cnt==1, all stalls SHALL be 0 and the FSM SHALL return to RUN, giving exactly MUL_LAT-1 stall cycles per op.
REQ-014 E_mc_start, E_branch_taken and load-use SHALL be evaluated only in RUN with no freeze.
REQ-015 Load-use SHALL be detected as E_is_load AND E_reg_write AND E_rd!=0 AND ((D_uses_rs1 AND D_rs1==E_rd) OR (D_uses_rs2 AND D_rs2==E_rd)).
REQ-016 On load-use, stall_F=1, stall_D=1 and flush_E=1 SHALL be asserted in the same cycle, for one cycle only.
REQ-017 E_branch_taken=1 SHALL assert flush_D=1 and flush_E=1 for that cycle and SHALL suppress any load-use stall in that cycle.
REQ-018 Priority SHALL be: mem_freeze > MC_BUSY > E_branch_taken > E_mc_start > load-use; E_mc_start with E_branch_taken SHALL be treated as a branch, with no MC entry.
REQ-019 Register index 0 SHALL never cause a hazard.
REQ-020 stall_M SHALL be 1 only under mem_freeze.

Reset
REQ-021 While rst=0, the FSM SHALL be in RUN, cnt SHALL be 0, all outputs SHALL be 0 and any perf counters SHALL be 0, all asynchronously.
REQ-022 Reset asserted in MC_BUSY SHALL abort the op immediately, with stalls dropping without waiting for clk.
REQ-023 After rst deasserts, the first rising edge SHALL evaluate from RUN.

Configuration
REQ-024 With macro HAZARD_CTRL_PERF_EN defined, the block SHALL add 32-bit outputs perf_stall_cycles (cycles with stall_D=1) and perf_flushes (cycles with flush_D=1), both saturating at all ones.
REQ-025 Without HAZARD_CTRL_PERF_EN, those outputs and their counters SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-026 The shared package hazard_pkg SHALL hold the FSM state enum (RUN, MC_BUSY), the REG_ZERO constant and the counter width constant.
REQ-027 The perf counters SHALL be one sub-module, hazard_perf_cnt, with a saturating counter and enable, instantiated twice under the macro.

Verification
REQ-028 The bench SHALL cover load-use: E_is_load=1, E_reg_write=1, E_rd=5, D_rs1=5, D_uses_rs1=1 -> stall_F=stall_D=flush_E=1 for exactly one cycle.
REQ-029 The bench SHALL cover x0: the same stimulus as REQ-028 with E_rd=0 -> no stall and no flush.
REQ-030 The bench SHALL cover multi-cycle ops: MUL_LAT=3, E_mc_start pulse -> stall_E=1 for 2 cycles, mc_busy=1 for 2 cycles, then RUN.
REQ-031 The bench SHALL cover freeze during MC_BUSY: M_mem_req=1, M_mem_ready=0 for 4 cycles in MC_BUSY -> all four stalls=1, cnt held, and MC completes 1 cycle after ready.
REQ-032 The bench SHALL cover branch over load-use: E_branch_taken=1 with a load-use match -> flush_D=flush_E=1 and stall_D=0.
REQ-033 The bench SHALL cover reset mid-op: rst=0 asserted in MC_BUSY between edges -> stalls and mc_busy go to 0 immediately, and perf counters read 0.
